redundant_carry_resolver: RTL and testbench
===========================================

Name: redundant_carry_resolver

Overview:
- Multi-cycle normaliser for the `ADD_DIV`-way redundant limb format used by the Fp adder tree (carry field + value field per limb).
- Resolves carries one limb per cycle into a single binary integer.
- Optionally applies one conditional subtraction of the modulus.
- Sits between the L1/L2/L3 redundant adder stages and the QPMM multiplier operand input. It is a parametrised generalisation over limb count, limb width and carry width.

Parameters:
- `ADD_DIV`, 4: number of limbs; must be ≥ 2.
- `LIMB_W`, 68: value-field width per limb (`LEN_12M_TILDE`/`ADD_DIV`).
- `CARRY_W`, 8: carry-field width per limb (`L3_CARRY`); 1 and 2 are also supported (L1/L2 forms).
- `OUT_W`, `ADD_DIV*LIMB_W+CARRY_W+1`: result width (281 at defaults).
- `MOD`, BN254 prime `256'h2523648240000001ba344d80000000086121000000000013a700000000000013`: modulus for mode 1, zero-extended to `OUT_W`.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: synchronous active-high reset.
- `i_valid`, in, 1: input limbs valid.
- `o_ready`, out, 1: block can accept input.
- `i_limbs`, in, `ADD_DIV*(CARRY_W+LIMB_W)`: packed limbs. Limb j is `{carry_j, val_j}`; limb 0 is in the LSBs.
- `i_mode`, in, 1: 0 = normalise only; 1 = normalise, then subtract `MOD` if result ≥ `MOD`.
- `o_valid`, out, 1: result valid.
- `i_ready`, in, 1: consumer accepts result.
- `o_result`, out, `OUT_W`: binary result.
- `o_reduced`, out, 1: the subtraction was applied (mode 1 only).

Behaviour:
- **Value semantics:** `V = sum_j (carry_j*2^LIMB_W + val_j) * 2^(j*LIMB_W)`. `V` always fits in `OUT_W` bits; no truncation ever occurs.
- **Reset values:** `o_ready`=1, `o_valid`=0, `o_result`=0, `o_reduced`=0, FSM in IDLE, internal registers zero.
- **FSM states:** IDLE, PROP, SUB, DONE.
- **IDLE:**
  - `o_ready`=1.
  - On `i_valid` & `o_ready`: register `i_limbs` and `i_mode`, clear the running carry `rc` (`CARRY_W+1` bits), set limb index k=0, go to PROP.
  - Input is ignored in every other state (`o_ready`=0).
- **PROP:** one limb per cycle.
  - `s = val_k + rc`.
  - Result bits `[k*LIMB_W +: LIMB_W]` ← `s[LIMB_W-1:0]`.
  - `rc` ← `(s >> LIMB_W) + carry_k`.
  - After k = `ADD_DIV`-1, write bits `[ADD_DIV*LIMB_W +: CARRY_W+1]` ← final `rc`.
  - Then go to SUB if the registered mode is 1, else DONE.
- **SUB (single cycle):**
  - `d = result - MOD` at `OUT_W`+1 bits.
  - If no borrow (result ≥ `MOD`): result ← `d`, `o_reduced` ← 1. Otherwise result is unchanged, `o_reduced` ← 0.
  - Exactly one subtraction; inputs ≥ 2·`MOD` are not fully reduced. This is by design.
- **DONE:**
  - `o_valid`=1.
  - `o_result` and `o_reduced` are held stable until `i_ready`.
  - On `o_valid` & `i_ready`: go to IDLE. `o_ready`=1 in the following cycle. `o_result` keeps its value; the bench must not check it while `o_valid`=0.
- **Latency:**
  - Accept at edge T.
  - Mode 0: `o_valid` first seen high after edge T+`ADD_DIV`.
  - Mode 1: `o_valid` first seen high after edge T+`ADD_DIV`+1.
- **Throughput:** one operation per `ADD_DIV`+2 (mode 0) or `ADD_DIV`+3 (mode 1) cycles with `i_ready` held high.
- **Mode 0:** `o_reduced` is always 0.
- **Backpressure:** `i_ready` low in DONE stalls indefinitely with outputs frozen.
- **Reset:** `i_rst` in any state, including mid-PROP or mid-SUB, aborts the operation and returns all outputs to reset values on the next edge. No partial result is ever flagged valid.
- **Simultaneous events:** `i_rst` has priority over both handshakes.
- **Arithmetic:** all arithmetic is unsigned. `rc` never exceeds `2^(CARRY_W+1)-1`.

Test Plan:
- **Basic normalise:** mode 0, limbs {c=0,v=1},{0,2},{0,3},{0,4} → `o_result` = `1 + 2<<68 + 3<<136 + 4<<204`, `o_reduced`=0, `o_valid` high exactly 4 cycles after accept.
- **Full ripple:** all `val_j` = `2^68-1`, `carry_0`=1, other carries 0 → `o_result` = `2^272 + 2^68 - 1`. The carry must ripple through all limbs.
- **Max input:** all `val_j` = `2^68-1`, all `carry_j`=255 → `o_result` = `(2^272-1) + 255*(2^68+2^136+2^204+2^272)` with bit 280 exercised; matches the golden model.
- **Mode 1 boundaries:**
  - `V=MOD+5` → result 5, `o_reduced`=1.
  - `V=MOD` → 0, `o_reduced`=1.
  - `V=MOD-1` → `MOD-1`, `o_reduced`=0.
  - Latency is 5 cycles in each case.
- **Backpressure:** `i_ready`=0 for 3 cycles in DONE while `i_valid` pulses with new data → `o_result` stable, `o_ready`=0, new data ignored. Releasing `i_ready` completes the handshake and `o_ready`=1 the next cycle.
- **Reset mid-op:** assert `i_rst` during PROP k=2 → next cycle `o_valid`=0, `o_ready`=1, `o_result`=0. A following operation then completes correctly.

Source files
------------

// File: rtl/redundant_carry_resolver.sv
// redundant_carry_resolver: resolves redundant carry/value limbs into one binary integer, with an optional single modular subtraction
module redundant_carry_resolver #(
  parameter int ADD_DIV = 4,
  parameter int LIMB_W = 68,
  parameter int CARRY_W = 8,
  parameter int OUT_W = ADD_DIV*LIMB_W+CARRY_W+1,
  parameter logic [255:0] MOD = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [ADD_DIV*(CARRY_W+LIMB_W)-1:0] i_limbs,
  input  logic                                i_mode,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [OUT_W-1:0]                    o_result,
  output logic                                o_reduced
);
  localparam int LW = CARRY_W+LIMB_W;
  localparam int K_W = $clog2(ADD_DIV);
  localparam logic [OUT_W-1:0] MOD_X = OUT_W'(MOD);
  typedef enum logic [1:0] {IDLE, PROP, SUB, DONE} state_t;
  state_t                      r_state, w_next;
  logic [ADD_DIV*LW-1:0]       r_limbs;
  logic                        r_mode;
  logic [CARRY_W:0]            r_rc;
  logic [K_W-1:0]              r_k;
  logic [OUT_W-1:0]            r_result;
  logic                        r_reduced;
  logic [LW-1:0]               w_limb;
  logic [LIMB_W:0]             w_sum;
  logic [CARRY_W:0]            w_rc_next;
  logic [OUT_W:0]              w_diff;
  logic                        w_last;
  assign w_limb    = r_limbs[r_k*LW +: LW];
  assign w_sum     = {1'b0, w_limb[LIMB_W-1:0]} + (LIMB_W+1)'(r_rc);
  assign w_rc_next = (CARRY_W+1)'(w_sum[LIMB_W]) + (CARRY_W+1)'(w_limb[LIMB_W +: CARRY_W]);
  assign w_diff    = {1'b0, r_result} - {1'b0, MOD_X};
  assign w_last    = r_k == K_W'(ADD_DIV-1);
  assign o_result  = r_result;
  assign o_reduced = r_reduced;
  // state register; reset aborts any operation in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        w_next = i_valid ? PROP : IDLE;
      end
      PROP: w_next = w_last ? (r_mode ? SUB : DONE) : PROP;
      SUB: w_next = DONE;
      default: begin
        o_valid = 1'b1;
        w_next = i_ready ? IDLE : DONE;
      end
    endcase
  end
  // datapath: capture operands, ripple one limb per cycle, then optionally subtract the modulus once
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_limbs <= '0;
      r_mode <= 1'b0;
      r_rc <= '0;
      r_k <= '0;
      r_result <= '0;
      r_reduced <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_limbs <= i_limbs;
          r_mode <= i_mode;
          r_rc <= '0;
          r_k <= '0;
          r_reduced <= 1'b0;
        end
        PROP: begin
          r_result[r_k*LIMB_W +: LIMB_W] <= w_sum[LIMB_W-1:0];
          r_rc <= w_rc_next;
          r_k <= r_k + K_W'(1);
          if (w_last) r_result[ADD_DIV*LIMB_W +: CARRY_W+1] <= w_rc_next;
        end
        SUB: if (!w_diff[OUT_W]) begin
          r_result <= w_diff[OUT_W-1:0];
          r_reduced <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_redundant_carry_resolver.sv
// tb_redundant_carry_resolver: directed and random checks against an arithmetic reference model
module tb_redundant_carry_resolver;
  localparam int A = 4, L = 68, C = 8, OW = A*L+C+1, BW = A*(C+L);
  localparam logic [255:0] MOD = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
  logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_mode = 1'b0, i_ready = 1'b0;
  logic [BW-1:0] i_limbs = '0;
  logic o_ready, o_valid, o_reduced;
  logic [OW-1:0] o_result;
  int errors = 0, checks = 0;
  redundant_carry_resolver dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_limbs(i_limbs), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_reduced(o_reduced)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void ref_model(input logic [BW-1:0] limbs, input logic mode, output logic [299:0] res, output logic red);
    logic [299:0] v = '0;
    for (int j = 0; j < A; j++)
      v = v + (((300'(limbs[j*(C+L)+L +: C])) << L) + 300'(limbs[j*(C+L) +: L])) * (300'(1) << (j*L));
    red = mode && (v >= 300'(MOD));
    res = red ? v - 300'(MOD) : v;
  endfunction
  function automatic logic [BW-1:0] pack(input logic [299:0] v);
    logic [BW-1:0] p = '0;
    for (int j = 0; j < A; j++) p[j*(C+L) +: L] = v[j*L +: L];
    return p;
  endfunction
  function automatic logic [BW-1:0] rnd_limbs();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[BW-1:0];
  endfunction
  task automatic start_op(input logic [BW-1:0] limbs, input logic mode, input string tag);
    @(negedge i_clk);
    chk({tag, "_rdy"}, 300'(o_ready), 300'(1));
    i_valid = 1'b1; i_limbs = limbs; i_mode = mode;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask
  task automatic wait_check(input logic [BW-1:0] limbs, input logic mode, input string tag, input logic [299:0] exp_res, input logic exp_red);
    int n = 0;
    while (!o_valid && n < 20) begin @(negedge i_clk); n++; end
    chk({tag, "_lat"}, 300'(n), mode ? 300'(5) : 300'(4));
    chk({tag, "_res"}, 300'(o_result), exp_res);
    chk({tag, "_red"}, 300'(o_reduced), 300'(exp_red));
  endtask
  task automatic release_op(input string tag);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    chk({tag, "_vld0"}, 300'(o_valid), 300'(0));
    chk({tag, "_rdy1"}, 300'(o_ready), 300'(1));
  endtask
  task automatic do_op(input logic [BW-1:0] limbs, input logic mode, input string tag, input logic [299:0] exp_res, input logic exp_red);
    start_op(limbs, mode, tag);
    wait_check(limbs, mode, tag, exp_res, exp_red);
    release_op(tag);
  endtask
  initial begin
    logic [BW-1:0] lb;
    logic [299:0] er, hold, one;
    logic ed, md;
    one = 300'(1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_rdy", 300'(o_ready), 300'(1));
    chk("rst_vld", 300'(o_valid), 300'(0));
    chk("rst_res", 300'(o_result), 300'(0));
    chk("rst_red", 300'(o_reduced), 300'(0));
    lb = '0;
    lb[0 +: L] = L'(1); lb[76 +: L] = L'(2); lb[152 +: L] = L'(3); lb[228 +: L] = L'(4);
    do_op(lb, 1'b0, "basic", one + (300'(2) << 68) + (300'(3) << 136) + (300'(4) << 204), 1'b0);
    lb = '0;
    for (int j = 0; j < A; j++) lb[j*(C+L) +: L] = '1;
    lb[L +: C] = C'(1);
    do_op(lb, 1'b0, "ripple", (one << 272) + (one << 68) - one, 1'b0);
    lb = '1;
    do_op(lb, 1'b0, "max", ((one << 272) - one) + 300'(255) * ((one << 68) + (one << 136) + (one << 204) + (one << 272)), 1'b0);
    do_op(pack(300'(MOD) + 300'(5)), 1'b1, "mod_p5", 300'(5), 1'b1);
    do_op(pack(300'(MOD)), 1'b1, "mod_eq", 300'(0), 1'b1);
    do_op(pack(300'(MOD) - one), 1'b1, "mod_m1", 300'(MOD) - one, 1'b0);
    lb = rnd_limbs();
    ref_model(lb, 1'b0, er, ed);
    start_op(lb, 1'b0, "bp");
    wait_check(lb, 1'b0, "bp", er, ed);
    hold = 300'(o_result);
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_limbs = rnd_limbs(); i_mode = 1'b1;
      @(negedge i_clk);
      chk("bp_hold", 300'(o_result), hold);
      chk("bp_rdy0", 300'(o_ready), 300'(0));
      chk("bp_vld1", 300'(o_valid), 300'(1));
    end
    i_valid = 1'b0;
    release_op("bp");
    lb = rnd_limbs();
    start_op(lb, 1'b0, "rstmid");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rstmid_vld", 300'(o_valid), 300'(0));
    chk("rstmid_rdy", 300'(o_ready), 300'(1));
    chk("rstmid_res", 300'(o_result), 300'(0));
    lb = rnd_limbs();
    ref_model(lb, 1'b1, er, ed);
    do_op(lb, 1'b1, "after_rst", er, ed);
    for (int i = 0; i < 16; i++) begin
      lb = (i % 4 == 3) ? pack(300'(MOD) + 300'($urandom_range(0, 3)) - 300'(2)) : rnd_limbs();
      md = (i % 4 == 3) ? 1'b1 : 1'($urandom);
      ref_model(lb, md, er, ed);
      do_op(lb, md, "rand", er, ed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
